mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Clocked bus-side controller directly upstream of the 256x8 byte-addressed RAM.
- Accepts one load/store request at a time from the CPU datapath and validates it: size, range and alignment.
- Drives the RAM's rw/mov/address/typeData/DataIn handshake, waits for moc with a timeout, then returns sign- or zero-extended read data or an error as a one-cycle response.

Parameters:
- ADDR_LIMIT, 256: memory size in bytes; accesses beyond it are rejected.
- TIMEOUT, 15: maximum WAIT cycles for moc before an error response.
- CHECK_ALIGN, 1: 1 = halfword must be 2-aligned and word must be 4-aligned; 0 = no alignment check.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and accepting.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; 1 = request rejected or timed out.
- mem_rw  out  1  to RAM rw (1 read, 0 write).
- mem_mov  out  1  to RAM mov.
- mem_address  out  32  to RAM address.
- mem_typeData  out  2  to RAM typeData.
- mem_DataIn  out  32  to RAM DataIn.
- mem_DataOut  in  32  from RAM DataOut.
- mem_moc  in  1  from RAM moc.

Behaviour:
- Clock and reset: one clock (clk). reset_n is asynchronous and active-low.
- Reset values (also the values forced on reset_n low mid-operation):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_rw = 1 (read, so no write can occur), mem_mov = 0, mem_address = 0, mem_typeData = 0, mem_DataIn = 0, timeout counter = 0.
- All state outputs are registered.
- States:
  - IDLE: req_ready = 1.
    - When req_valid = 1, latch the request and evaluate errors.
    - Errors: req_size = 11; or addr + nbytes > ADDR_LIMIT, computed in 33 bits (nbytes = 1, 2 or 4); or, with CHECK_ALIGN = 1, a misaligned halfword or word.
    - Error → RESP with err = 1; the memory is never strobed.
    - No error → SETUP.
  - SETUP (1 cycle): mem_address, mem_typeData, mem_rw = ~req_write and mem_DataIn (= req_wdata) are stable while mem_mov = 0. mem_rw may only change while mem_mov = 0.
  - STROBE (1 cycle): mem_mov = 1; mem_moc is ignored, because the RAM leaves moc high from prior accesses.
  - WAIT: mem_mov = 1, and mem_moc is sampled every cycle.
    - moc = 1: latch mem_DataOut, drop mem_mov, go to RESP with err = 0.
    - Counter reaches TIMEOUT: drop mem_mov, go to RESP with err = 1.
  - RESP (1 cycle): resp_valid = 1, req_ready = 0, then return to IDLE. resp_valid and resp_err clear the following cycle.
- Latency: accept at cycle T, SETUP at T+1, STROBE at T+2, first WAIT at T+3, resp_valid at T+4 minimum. An error detected in IDLE responds at T+1.
- Load data extraction:
  - Byte is mem_DataOut[7:0], halfword is [15:0], word is [31:0] (the RAM is big-endian and right-justifies the result).
  - Extend to 32 bits per req_signed; word loads are unmodified.
- Stores: resp_rdata = 0. Byte stores use wdata[7:0], halfword stores [15:0]; upper bits are don't-care to the RAM.
- Backpressure: req_valid while req_ready = 0 is ignored (not queued); there is no backpressure on the response.
- Address wrap: 0xFFFFFFFF plus size must not wrap. The 33-bit sum flags it as an error.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - state enum IDLE/SETUP/STROBE/WAIT/RESP;
  - a function returning nbytes per size.
- One natural sub-module: load_extend, a combinational block taking (data, size, signed) and producing 32-bit extended data.

Test Plan:
- Word store then load: store 0xDEADBEEF at addr 0x10, then load word at 0x10 → resp_rdata = 0xDEADBEEF, err = 0, resp_valid at T+4 for each.
- Signed and unsigned byte loads: store byte 0x80 at 0x21, load signed → 0xFFFFFF80, load unsigned → 0x00000080. Halfword 0x8001 signed at 0x22 → 0xFFFF8001.
- Rejected requests: size 11 → err at T+1 and mem_mov never rises. Word at 0x13 → misalign err. Word at 0xFD → range err. Halfword at 0x13 with CHECK_ALIGN = 0 → completes normally.
- Timeout: mem_moc tied 0 → resp_err = 1 at T+3+TIMEOUT, mem_mov back to 0, no write committed; the next request is accepted.
- Reset mid-operation: assert reset_n = 0 during WAIT of a store → immediately mem_mov = 0, mem_rw = 1, req_ready = 1, no resp_valid. A subsequent load returns the correct old data.
- Protocol checker throughout: mem_rw never changes while mem_mov = 1; mem_address and mem_DataIn are stable from SETUP until mov falls; req_ready = 0 outside IDLE; resp_valid is exactly one cycle wide.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and size helper for the memory access controller.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      WAIT,
      RESP
   } state_t;

   function automatic logic [2:0] size_nbytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_nbytes = 3'd1;
         SZ_HALF: size_nbytes = 3'd2;
         default: size_nbytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response channel plus the RAM rw/mov/moc handshake, seen from both ends.
interface mem_access_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_rw;
   logic        mem_mov;
   logic [31:0] mem_address;
   logic [1:0]  mem_typeData;
   logic [31:0] mem_DataIn;
   logic [31:0] mem_DataOut;
   logic        mem_moc;

   // controller side
   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_rw, mem_mov, mem_address, mem_typeData, mem_DataIn,
      input  mem_DataOut, mem_moc
   );

   // CPU datapath and RAM side
   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_rw, mem_mov, mem_address, mem_typeData, mem_DataIn,
      output mem_DataOut, mem_moc
   );

endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of right-justified RAM read data to 32 bits.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] ext
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   assign byte_s = data[7:0];
   assign half_s = data[15:0];

   always_comb begin
      ext = data;
      case (size)
         SZ_BYTE: ext = sgn ? 32'(byte_s) : {24'h0, data[7:0]};
         SZ_HALF: ext = sgn ? 32'(half_s) : {16'h0, data[15:0]};
         default: ext = data;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Validates one CPU load/store at a time and runs the RAM rw/mov/moc handshake
// with a bounded wait, returning extended load data or an error as a one-cycle pulse.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_LIMIT  = 256,
   parameter int TIMEOUT     = 15,
   parameter int CHECK_ALIGN = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   mem_access_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               lat_write;
   logic [1:0]         lat_size;
   logic               lat_signed;
   logic [32:0]        end_addr;
   logic               req_bad;
   logic [31:0]        ext_data;

   // The extra bit keeps 0xFFFFFFFF + n from wrapping back into range.
   always_comb begin
      end_addr = {1'b0, bus.req_addr} + 33'(size_nbytes(bus.req_size));
      req_bad  = (bus.req_size == SZ_ILL) || (end_addr > 33'(ADDR_LIMIT));
      if (CHECK_ALIGN != 0) begin
         if ((bus.req_size == SZ_HALF) && bus.req_addr[0])
            req_bad = 1'b1;
         if ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
            req_bad = 1'b1;
      end
   end

   load_extend u_ext (
      .data (bus.mem_DataOut),
      .size (lat_size),
      .sgn  (lat_signed),
      .ext  (ext_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         cnt              <= '0;
         lat_write        <= 1'b0;
         lat_size         <= SZ_BYTE;
         lat_signed       <= 1'b0;
         bus.req_ready    <= 1'b1;
         bus.resp_valid   <= 1'b0;
         bus.resp_err     <= 1'b0;
         bus.resp_rdata   <= '0;
         bus.mem_rw       <= 1'b1;
         bus.mem_mov      <= 1'b0;
         bus.mem_address  <= '0;
         bus.mem_typeData <= '0;
         bus.mem_DataIn   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  bus.req_ready <= 1'b0;
                  lat_write     <= bus.req_write;
                  lat_size      <= bus.req_size;
                  lat_signed    <= bus.req_signed;
                  if (req_bad) begin
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= '0;
                     state          <= RESP;
                  end else begin
                     // Address, type, direction and data settle a full cycle before mov.
                     bus.mem_address  <= bus.req_addr;
                     bus.mem_typeData <= bus.req_size;
                     bus.mem_rw       <= ~bus.req_write;
                     bus.mem_DataIn   <= bus.req_wdata;
                     state            <= SETUP;
                  end
               end
            end
            SETUP: begin
               bus.mem_mov <= 1'b1;
               state       <= STROBE;
            end
            STROBE: begin
               // moc may still be high from the previous access; do not look at it yet.
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (bus.mem_moc) begin
                  bus.mem_mov    <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b0;
                  bus.resp_rdata <= lat_write ? 32'h0 : ext_data;
                  state          <= RESP;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  bus.mem_mov    <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b1;
                  bus.resp_rdata <= '0;
                  state          <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               bus.resp_valid <= 1'b0;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= '0;
               bus.mem_rw     <= 1'b1;
               bus.req_ready  <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: big-endian RAM model behind the controller, scoreboard of expected responses.
module tb_mem_access_ctrl;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_ctrl_if bus ();
   mem_access_ctrl_if bus_na ();

   mem_access_ctrl #(.ADDR_LIMIT(256), .TIMEOUT(15), .CHECK_ALIGN(1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
   mem_access_ctrl #(.ADDR_LIMIT(256), .TIMEOUT(15), .CHECK_ALIGN(0)) dut_na (
      .clk(clk), .reset_n(reset_n), .bus(bus_na));

   // shared request fields; sel_na steers req_valid to the unaligned-allowed instance
   logic        r_valid = 1'b0, r_wr = 1'b0, r_sg = 1'b0, sel_na = 1'b0;
   logic [1:0]  r_sz = 2'b00;
   logic [31:0] r_addr = '0, r_wd = '0;

   assign bus.req_valid     = r_valid & ~sel_na;
   assign bus_na.req_valid  = r_valid & sel_na;
   assign bus.req_write     = r_wr;
   assign bus_na.req_write  = r_wr;
   assign bus.req_size      = r_sz;
   assign bus_na.req_size   = r_sz;
   assign bus.req_signed    = r_sg;
   assign bus_na.req_signed = r_sg;
   assign bus.req_addr      = r_addr;
   assign bus_na.req_addr   = r_addr;
   assign bus.req_wdata     = r_wd;
   assign bus_na.req_wdata  = r_wd;

   logic        rv_sel, err_sel, rdy_sel;
   logic [31:0] rd_sel;
   assign rv_sel  = sel_na ? bus_na.resp_valid : bus.resp_valid;
   assign err_sel = sel_na ? bus_na.resp_err   : bus.resp_err;
   assign rdy_sel = sel_na ? bus_na.req_ready  : bus.req_ready;
   assign rd_sel  = sel_na ? bus_na.resp_rdata : bus.resp_rdata;

   // RAM model: big-endian, right-justified reads with junk upper bits, optional latency.
   logic [7:0]  ram [256] = '{default: 8'h00};
   logic        ram_moc = 1'b0, started = 1'b0, ram_dead = 1'b0, fire;
   logic [31:0] ram_dout = '0, rd_val;
   logic [7:0]  ra;
   int          ram_lat = 0, ram_cnt = 0;

   assign ra              = bus.mem_address[7:0];
   assign bus.mem_moc     = ram_moc;
   assign bus.mem_DataOut = ram_dout;
   assign fire = bus.mem_mov && !ram_dead &&
                 ((!started && ram_lat == 0) || (started && ram_cnt == 1));

   always_comb begin
      case (bus.mem_typeData)
         SZ_BYTE: rd_val = {24'hA5A5A5, ram[ra]};
         SZ_HALF: rd_val = {16'hA5A5, ram[ra], ram[ra + 8'd1]};
         default: rd_val = {ram[ra], ram[ra + 8'd1], ram[ra + 8'd2], ram[ra + 8'd3]};
      endcase
   end

   always @(posedge clk) begin
      if (!bus.mem_mov) begin
         started <= 1'b0;
      end else if (!started) begin
         started <= 1'b1;
         ram_cnt <= ram_lat;
         ram_moc <= fire;
      end else if (ram_cnt != 0) begin
         ram_cnt <= ram_cnt - 1;
         if (fire) ram_moc <= 1'b1;
      end
      if (fire) begin
         if (!bus.mem_rw) begin
            case (bus.mem_typeData)
               SZ_BYTE: ram[ra] <= bus.mem_DataIn[7:0];
               SZ_HALF: begin
                  ram[ra]        <= bus.mem_DataIn[15:8];
                  ram[ra + 8'd1] <= bus.mem_DataIn[7:0];
               end
               default: begin
                  ram[ra]        <= bus.mem_DataIn[31:24];
                  ram[ra + 8'd1] <= bus.mem_DataIn[23:16];
                  ram[ra + 8'd2] <= bus.mem_DataIn[15:8];
                  ram[ra + 8'd3] <= bus.mem_DataIn[7:0];
               end
            endcase
         end else begin
            ram_dout <= rd_val;
         end
      end
   end

   // Always-ready responder for the second instance.
   logic na_moc = 1'b0;
   always @(posedge clk) na_moc <= bus_na.mem_mov;
   assign bus_na.mem_moc     = na_moc;
   assign bus_na.mem_DataOut = 32'hA5A51234;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Handshake watcher on the main RAM port.
   int          proto_err = 0;
   logic        p_mov = 1'b0, p_rw = 1'b1, p_rv = 1'b0;
   logic [31:0] p_addr = '0, p_din = '0;
   always @(negedge clk) begin
      if (reset_n && ((p_mov && bus.mem_mov &&
                       (bus.mem_rw !== p_rw || bus.mem_address !== p_addr || bus.mem_DataIn !== p_din)) ||
                      (bus.mem_mov && bus.req_ready) ||
                      (bus.resp_valid && (bus.req_ready || p_rv))))
         proto_err <= proto_err + 1;
      p_mov  <= bus.mem_mov;
      p_rw   <= bus.mem_rw;
      p_rv   <= bus.resp_valid;
      p_addr <= bus.mem_address;
      p_din  <= bus.mem_DataIn;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", t, obs, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic [31:0] rd;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   task automatic issue(input string tag, input bit na, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int hold = 0);
      exp_t e;
      int   t_acc;
      bit   got, mov_seen;
      @(negedge clk);
      sel_na = na;
      r_wr = wr; r_sz = sz; r_sg = sg; r_addr = addr; r_wd = wd; r_valid = 1'b1;
      #1;
      chk({tag, "_ready"}, 32'(rdy_sel), 32'h1);
      sb.push_back('{tag, exp_rd, exp_err, exp_lat});
      t_acc = cyc;
      @(posedge clk); #1;
      for (int h = 0; h < hold; h++) begin
         r_addr = r_addr + 32'h10;
         r_wd   = ~r_wd;
         @(posedge clk); #1;
      end
      r_valid = 1'b0;
      got = 1'b0;
      mov_seen = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (rv_sel) got = 1'b1;
         else mov_seen = mov_seen | bus.mem_mov;
      end
      e = sb.pop_front();
      if (!got) begin
         chk({e.tag, "_no_response"}, 32'(got), 32'h1);
      end else begin
         chk({e.tag, "_rdata"}, rd_sel, e.rd);
         chk({e.tag, "_err"}, 32'(err_sel), 32'(e.err));
         chk({e.tag, "_latency"}, 32'(cyc - t_acc), 32'(e.lat));
         chk({e.tag, "_mov_low"}, 32'(bus.mem_mov), 32'h0);
         if (e.err && e.lat == 1) chk({e.tag, "_no_strobe"}, 32'(mov_seen), 32'h0);
      end
      sel_na = 1'b0;
   endtask

   initial begin
      int stray;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'h1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_mem_rw", 32'(bus.mem_rw), 32'h1);
      chk("rst_mem_mov", 32'(bus.mem_mov), 32'h0);
      chk("rst_mem_address", bus.mem_address, 32'h0);
      chk("rst_mem_type", 32'(bus.mem_typeData), 32'h0);
      chk("rst_mem_datain", bus.mem_DataIn, 32'h0);
      reset_n = 1'b1;

      issue("st_w10", 0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 4);
      issue("ld_w10", 0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 4);
      issue("ld_b10", 0, 0, SZ_BYTE, 0, 32'h10, 32'h0, 32'h000000DE, 0, 4);
      issue("st_b21", 0, 1, SZ_BYTE, 0, 32'h21, 32'hFFFFFF80, 32'h0, 0, 4);
      issue("ld_b21s", 0, 0, SZ_BYTE, 1, 32'h21, 32'h0, 32'hFFFFFF80, 0, 4);
      issue("ld_b21u", 0, 0, SZ_BYTE, 0, 32'h21, 32'h0, 32'h00000080, 0, 4);
      issue("st_h22", 0, 1, SZ_HALF, 0, 32'h22, 32'h12348001, 32'h0, 0, 4);
      issue("ld_h22s", 0, 0, SZ_HALF, 1, 32'h22, 32'h0, 32'hFFFF8001, 0, 4);
      issue("ld_h22u", 0, 0, SZ_HALF, 0, 32'h22, 32'h0, 32'h00008001, 0, 4);

      issue("bad_size", 0, 0, SZ_ILL, 0, 32'h10, 32'h0, 32'h0, 1, 1);
      issue("misalign_w13", 0, 0, SZ_WORD, 0, 32'h13, 32'h0, 32'h0, 1, 1);
      issue("misalign_h13", 0, 0, SZ_HALF, 0, 32'h13, 32'h0, 32'h0, 1, 1);
      issue("range_wFD", 0, 0, SZ_WORD, 0, 32'hFD, 32'h0, 32'h0, 1, 1);
      issue("range_w100", 0, 1, SZ_WORD, 0, 32'h100, 32'h1, 32'h0, 1, 1);
      issue("wrap_wFFFF", 0, 0, SZ_WORD, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 1);
      issue("edge_bFF", 0, 0, SZ_BYTE, 0, 32'hFF, 32'h0, 32'h0, 0, 4);
      issue("edge_wFC", 0, 0, SZ_WORD, 0, 32'hFC, 32'h0, 32'h0, 0, 4);
      issue("noalign_h13", 1, 0, SZ_HALF, 0, 32'h13, 32'h0, 32'h00001234, 0, 4);

      issue("bp_st_w50", 0, 1, SZ_WORD, 0, 32'h50, 32'hA1B2C3D4, 32'h0, 0, 4, 2);
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.resp_valid) stray++;
      end
      chk("bp_no_second_resp", 32'(stray), 32'h0);
      issue("bp_ld_w50", 0, 0, SZ_WORD, 0, 32'h50, 32'h0, 32'hA1B2C3D4, 0, 4);
      issue("bp_ld_w60", 0, 0, SZ_WORD, 0, 32'h60, 32'h0, 32'h0, 0, 4);

      ram_dead = 1'b1;
      issue("tmo_st_w30", 0, 1, SZ_WORD, 0, 32'h30, 32'h55667788, 32'h0, 1, 18);
      ram_dead = 1'b0;
      issue("tmo_ld_w30", 0, 0, SZ_WORD, 0, 32'h30, 32'h0, 32'h0, 0, 4);

      issue("pre_st_w40", 0, 1, SZ_WORD, 0, 32'h40, 32'h11223344, 32'h0, 0, 4);
      ram_lat = 6;
      @(negedge clk);
      r_wr = 1'b1; r_sz = SZ_WORD; r_sg = 1'b0; r_addr = 32'h40; r_wd = 32'hCAFEF00D; r_valid = 1'b1;
      @(posedge clk); #1;
      r_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_wait_mov", 32'(bus.mem_mov), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_mov", 32'(bus.mem_mov), 32'h0);
      chk("mid_rst_rw", 32'(bus.mem_rw), 32'h1);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'h1);
      chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      stray = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.resp_valid) stray++;
      end
      chk("mid_rst_no_resp", 32'(stray), 32'h0);
      ram_lat = 0;
      issue("post_rst_ld_w40", 0, 0, SZ_WORD, 0, 32'h40, 32'h0, 32'h11223344, 0, 4);

      @(negedge clk);
      chk("protocol", 32'(proto_err), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
